// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-requester UART byte transmitter arbiter.
package uart_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Zero latency; no backpressure of its own (pure function of req and ptr).
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_vld,
  output logic [IDX_W-1:0]   gnt_idx
);

  int               sum;
  logic [IDX_W-1:0] cand;

  // Scan farthest offset first so the nearest valid requester overwrites last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = 0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum  = int'(ptr) + k;
      cand = IDX_W'(sum % NUM_REQ);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one byte at a time to a UART transmitter.
// Byte accepted in FETCH is offered on tx_valid the next cycle; optional stall timeout via UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic                       tx_valid,
  output logic [BYTE_W-1:0]          tx_data,
  input  logic                       tx_rdy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               last_q, last_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   grant_next;
  logic               sel_valid;
  logic               sel_last;
  logic [BYTE_W-1:0]  sel_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

  assign sel_valid  = req_valid[grant_q];
  assign sel_last   = req_last[grant_q];
  assign sel_data   = req_data[BYTE_W*grant_q +: BYTE_W];
  assign grant_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    last_d   = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = FETCH;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      FETCH: begin
        if (sel_valid) begin
          data_d  = sel_data;
          last_d  = sel_last;
          state_d = SEND;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Stalled owner: drop the packet and move the pointer past it.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          rr_ptr_d  = grant_next;
          grant_d   = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (tx_rdy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (last_q) begin
            rr_ptr_d = grant_next;
            grant_d  = '0;
            state_d  = IDLE;
          end else begin
            state_d = FETCH;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      last_q    <= last_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    req_rdy = '0;
    if (state_q == FETCH) req_rdy[grant_q] = 1'b1;
  end

  assign tx_valid = (state_q == SEND);
  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the byte transmitter (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: mid-packet stall limit, used only when UART_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 req_last  input  NUM_REQ  per-requester last-byte-of-packet flag, qualified by req_valid.
REQ-007 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_rdy  output  NUM_REQ  one-hot byte accept; a byte transfers when req_valid[i] and req_rdy[i] are both high.
REQ-009 tx_valid  output  1  byte offered to the transmitter.
REQ-010 tx_data  output  8  byte to transmit.
REQ-011 tx_rdy  input  1  transmitter accepts; handoff when tx_valid and tx_rdy are both high.
REQ-012 tx_done  input  1  one-cycle pulse when the stop bit of the current byte completes.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the owning requester; 0 when idle.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 timeout_err  output  1  one-cycle pulse when a packet is force-terminated.

Function
REQ-016 FSM states: IDLE, FETCH, SEND, WAIT_DONE.
REQ-017 IDLE: if any req_valid is high, grant the first valid requester at or after rr_ptr (round-robin, wrapping NUM_REQ-1 to 0), then go to FETCH; stay in IDLE otherwise.
REQ-018 FETCH: req_rdy[grant_id] is high and all other req_rdy bits are low; when the granted requester's byte transfers, latch data and last into registers, then go to SEND.
REQ-019 SEND: tx_valid is high and tx_data holds the latched byte, stable until tx_rdy; on handoff, go to WAIT_DONE.
REQ-020 WAIT_DONE: on tx_done, go to FETCH (same grant) if the latched last is 0; if it is 1, go to IDLE and set rr_ptr = grant_id+1 mod NUM_REQ.
REQ-021 A packet is never interleaved; other requesters' req_rdy stays low until the owning packet ends.
REQ-022 Handoff latency: a byte accepted in FETCH at cycle N asserts tx_valid at N+1.
REQ-023 At most one byte is in flight; req_rdy is low outside FETCH.
REQ-024 tx_done seen outside WAIT_DONE is ignored.
REQ-025 A single-byte packet (last=1 on the first byte) returns to IDLE after one tx_done.
REQ-026 Requester deasserting req_valid in FETCH: the arbiter holds the grant and waits; no rearbitration without UART_ARB_TIMEOUT_EN.

Reset
REQ-027 With rst high at a clock edge: state=IDLE, rr_ptr=0, grant_id=0, req_rdy=0, tx_valid=0, tx_data=0x00, busy=0, timeout_err=0, timeout counter=0.
REQ-028 Reset mid-packet abandons the packet immediately; the next arbitration starts from requester 0.

Configuration
REQ-029 Macro UART_ARB_TIMEOUT_EN defined: a counter clears on every FETCH entry and increments each FETCH cycle without a transfer; when it reaches TIMEOUT_CYCLES, pulse timeout_err for one cycle, go to IDLE, and advance rr_ptr past grant_id.
REQ-030 UART_ARB_TIMEOUT_EN undefined: no counter exists, timeout_err is tied to 0, and FETCH waits indefinitely.

Structure
REQ-031 Shared package uart_pkg holds the arb_state_t enum (IDLE, FETCH, SEND, WAIT_DONE), the byte width constant 8, and the default NUM_REQ.
REQ-032 One sub-module, rr_arbiter (combinational round-robin pick from a request vector and rr_ptr), is instantiated once; all other logic stays in uart_tx_arbiter.

Verification
REQ-033 Req0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) while req1 is also valid -> tx_data order 0x11,0x22,0x33, then grant_id=1.
REQ-034 All 4 requesters send 1-byte packets continuously from reset -> grants follow 0,1,2,3,0 and each tx_valid comes 1 cycle after its FETCH accept.
REQ-035 tx_rdy held low for 10 cycles in SEND -> tx_valid and tx_data stay stable for 10 cycles; the handoff occurs on the 11th.
REQ-036 rst asserted in WAIT_DONE of req2's packet -> all outputs are at reset values the next cycle, and the next grant goes to the lowest valid index.
REQ-037 UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, req1 stalls after its first byte -> timeout_err pulses once 16 cycles into FETCH, then req2 is granted.
REQ-038 Spurious tx_done pulse in IDLE and in SEND -> no state change and no extra tx_valid.
